// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Serves word loads/stores and moves whole 16-byte lines to/from data memory over a
// request/response port.
//
// State table:
//   IDLE       | ready for a CPU request; the tag lookup for the new request is done here
//   LOOKUP     | completes a hit (outputs already registered) or starts miss handling
//   EVICT_REQ  | m_req with the dirty victim line until m_ready
//   EVICT_WAIT | waits for the write response, then cleans the line
//   FILL_REQ   | m_req for the missing line until m_ready
//   FILL_WAIT  | waits for refill data and installs the new line
//   REFILLED   | completes the held request on the freshly installed line
//
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   is_input_valid_i, addr_i,
//   mem_read_i, mem_write_i, din_i  CPU request (read+write together counts as a write)
//   is_ready_o                      cache is in IDLE
//   is_output_valid_o, is_hit_o,
//   dout_o                          completion pulse, hit flag, load data (0 on stores)
//   m_req_o, m_we_o, m_addr_o,
//   m_wdata_o, m_ready_i            line request to memory (held until m_ready_i)
//   m_resp_valid_i, m_rdata_i       memory response / refill data
//   hit_count_o, miss_count_o       wrapping event counters
module dcache_wb #(
   parameter int NUM_SETS   = 16,
   parameter int LINE_WORDS = 4,
   parameter int ADDR_W     = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     is_input_valid_i,
   input  logic [ADDR_W-1:0]        addr_i,
   input  logic                     mem_read_i,
   input  logic                     mem_write_i,
   input  logic [31:0]              din_i,
   output logic                     is_ready_o,
   output logic                     is_output_valid_o,
   output logic [31:0]              dout_o,
   output logic                     is_hit_o,
   output logic                     m_req_o,
   output logic                     m_we_o,
   output logic [ADDR_W-1:0]        m_addr_o,
   output logic [32*LINE_WORDS-1:0] m_wdata_o,
   input  logic                     m_ready_i,
   input  logic                     m_resp_valid_i,
   input  logic [32*LINE_WORDS-1:0] m_rdata_i,
   output logic [31:0]              hit_count_o,
   output logic [31:0]              miss_count_o
);

   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = ADDR_W - 4 - IDX_W;

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_EVICT_REQ, S_EVICT_WAIT, S_FILL_REQ, S_FILL_WAIT, S_REFILLED
   } state_t;

   state_t                   state_q;
   logic [NUM_SETS-1:0]      valid_q;
   logic [NUM_SETS-1:0]      dirty_q;
   logic [TAG_W-1:0]         tag_q  [NUM_SETS];
   logic [31:0]              data_q [NUM_SETS][LINE_WORDS];

   logic [ADDR_W-1:0]        req_addr_q;
   logic [31:0]              req_din_q;
   logic                     req_we_q;
   logic                     hit_q;

   logic                     is_ready_q;
   logic                     is_output_valid_q;
   logic                     is_hit_q;
   logic [31:0]              dout_q;
   logic                     m_req_q;
   logic                     m_we_q;
   logic [ADDR_W-1:0]        m_addr_q;
   logic [32*LINE_WORDS-1:0] m_wdata_q;
   logic [31:0]              hit_count_q;
   logic [31:0]              miss_count_q;

   logic [IDX_W-1:0]         idx_in, idx_r;
   logic [TAG_W-1:0]         tag_in, tag_r;
   logic [1:0]               off_in, off_r;
   logic                     lookup_hit;
   logic                     accept;
   logic                     fill_we;
   logic                     word_we;
   logic [32*LINE_WORDS-1:0] line_rd;
   logic                     unused_addr_bits;

   assign idx_in = addr_i[4 +: IDX_W];
   assign tag_in = addr_i[ADDR_W-1 -: TAG_W];
   assign off_in = addr_i[3:2];
   assign idx_r  = req_addr_q[4 +: IDX_W];
   assign tag_r  = req_addr_q[ADDR_W-1 -: TAG_W];
   assign off_r  = req_addr_q[3:2];

   assign unused_addr_bits = ^{addr_i[1:0], req_addr_q[1:0]};

   assign accept     = is_input_valid_i && (mem_read_i || mem_write_i);
   // The lookup for a new request is evaluated in IDLE so that a hit's completion
   // pulse is already registered during LOOKUP, one cycle after acceptance.
   assign lookup_hit = valid_q[idx_in] && (tag_q[idx_in] == tag_in);

   assign fill_we = (state_q == S_FILL_WAIT) && m_resp_valid_i;
   assign word_we = req_we_q && (((state_q == S_LOOKUP) && hit_q) || (state_q == S_REFILLED));

   always_comb begin
      line_rd = '0;
      for (int w = 0; w < LINE_WORDS; w++) begin
         line_rd[32*w +: 32] = data_q[idx_r][w];
      end
   end

   // Tag and data arrays are not reset; valid bits gate their use.
   always_ff @(posedge clk_i) begin
      if (fill_we) begin
         tag_q[idx_r] <= tag_r;
         for (int w = 0; w < LINE_WORDS; w++) begin
            data_q[idx_r][w] <= m_rdata_i[32*w +: 32];
         end
      end
      if (word_we) begin
         data_q[idx_r][off_r] <= req_din_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q           <= S_IDLE;
         valid_q           <= '0;
         dirty_q           <= '0;
         req_addr_q        <= '0;
         req_din_q         <= '0;
         req_we_q          <= 1'b0;
         hit_q             <= 1'b0;
         is_ready_q        <= 1'b1;
         is_output_valid_q <= 1'b0;
         is_hit_q          <= 1'b0;
         dout_q            <= '0;
         m_req_q           <= 1'b0;
         m_we_q            <= 1'b0;
         m_addr_q          <= '0;
         m_wdata_q         <= '0;
         hit_count_q       <= '0;
         miss_count_q      <= '0;
      end else begin
         is_output_valid_q <= 1'b0;
         is_hit_q          <= 1'b0;
         dout_q            <= '0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  req_addr_q <= addr_i;
                  req_din_q  <= din_i;
                  req_we_q   <= mem_write_i;
                  hit_q      <= lookup_hit;
                  is_ready_q <= 1'b0;
                  state_q    <= S_LOOKUP;
                  if (lookup_hit) begin
                     is_output_valid_q <= 1'b1;
                     is_hit_q          <= 1'b1;
                     if (!mem_write_i) begin
                        dout_q <= data_q[idx_in][off_in];
                     end
                  end
               end
            end
            S_LOOKUP: begin
               if (hit_q) begin
                  if (req_we_q) begin
                     dirty_q[idx_r] <= 1'b1;
                  end
                  hit_count_q <= hit_count_q + 32'd1;
                  is_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end else begin
                  miss_count_q <= miss_count_q + 32'd1;
                  m_req_q      <= 1'b1;
                  if (valid_q[idx_r] && dirty_q[idx_r]) begin
                     m_we_q    <= 1'b1;
                     m_addr_q  <= {tag_q[idx_r], idx_r, 4'b0000};
                     m_wdata_q <= line_rd;
                     state_q   <= S_EVICT_REQ;
                  end else begin
                     m_we_q    <= 1'b0;
                     m_addr_q  <= {tag_r, idx_r, 4'b0000};
                     m_wdata_q <= '0;
                     state_q   <= S_FILL_REQ;
                  end
               end
            end
            S_EVICT_REQ: begin
               if (m_ready_i) begin
                  m_req_q   <= 1'b0;
                  m_we_q    <= 1'b0;
                  m_addr_q  <= '0;
                  m_wdata_q <= '0;
                  state_q   <= S_EVICT_WAIT;
               end
            end
            S_EVICT_WAIT: begin
               if (m_resp_valid_i) begin
                  dirty_q[idx_r] <= 1'b0;
                  m_req_q        <= 1'b1;
                  m_we_q         <= 1'b0;
                  m_addr_q       <= {tag_r, idx_r, 4'b0000};
                  state_q        <= S_FILL_REQ;
               end
            end
            S_FILL_REQ: begin
               if (m_ready_i) begin
                  m_req_q  <= 1'b0;
                  m_addr_q <= '0;
                  state_q  <= S_FILL_WAIT;
               end
            end
            S_FILL_WAIT: begin
               if (m_resp_valid_i) begin
                  valid_q[idx_r]    <= 1'b1;
                  dirty_q[idx_r]    <= 1'b0;
                  is_output_valid_q <= 1'b1;
                  if (!req_we_q) begin
                     dout_q <= m_rdata_i[32*off_r +: 32];
                  end
                  state_q <= S_REFILLED;
               end
            end
            S_REFILLED: begin
               if (req_we_q) begin
                  dirty_q[idx_r] <= 1'b1;
               end
               is_ready_q <= 1'b1;
               state_q    <= S_IDLE;
            end
            default: begin
               is_ready_q <= 1'b1;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   assign is_ready_o        = is_ready_q;
   assign is_output_valid_o = is_output_valid_q;
   assign is_hit_o          = is_hit_q;
   assign dout_o            = dout_q;
   assign m_req_o           = m_req_q;
   assign m_we_o            = m_we_q;
   assign m_addr_o          = m_addr_q;
   assign m_wdata_o         = m_wdata_q;
   assign hit_count_o       = hit_count_q;
   assign miss_count_o      = miss_count_q;

endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: directed bench for dcache_wb with a completion scoreboard and an
// inline memory responder that logs every line transaction.
module tb_dcache_wb;

   logic          clk_sys;
   logic          rst_n;
   logic          is_input_valid;
   logic [31:0]   addr;
   logic          mem_read;
   logic          mem_write;
   logic [31:0]   din;
   logic          is_ready;
   logic          is_output_valid;
   logic [31:0]   dout;
   logic          is_hit;
   logic          m_req;
   logic          m_we;
   logic [31:0]   m_addr;
   logic [127:0]  m_wdata;
   logic          m_ready;
   logic          m_resp_valid;
   logic [127:0]  m_rdata;
   logic [31:0]   hit_count;
   logic [31:0]   miss_count;

   typedef struct {
      logic        hit;
      logic [31:0] dout;
   } exp_t;

   typedef struct {
      logic [31:0]  addr;
      logic         we;
      logic [127:0] wdata;
   } txn_t;

   exp_t         sb_q[$];
   txn_t         txn_q[$];
   logic [127:0] mem [logic [31:0]];
   int           n_checks = 0;
   int           n_pass   = 0;

   dcache_wb dut (
      .clk_i            (clk_sys),
      .rst_ni           (rst_n),
      .is_input_valid_i (is_input_valid),
      .addr_i           (addr),
      .mem_read_i       (mem_read),
      .mem_write_i      (mem_write),
      .din_i            (din),
      .is_ready_o       (is_ready),
      .is_output_valid_o(is_output_valid),
      .dout_o           (dout),
      .is_hit_o         (is_hit),
      .m_req_o          (m_req),
      .m_we_o           (m_we),
      .m_addr_o         (m_addr),
      .m_wdata_o        (m_wdata),
      .m_ready_i        (m_ready),
      .m_resp_valid_i   (m_resp_valid),
      .m_rdata_i        (m_rdata),
      .hit_count_o      (hit_count),
      .miss_count_o     (miss_count)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [127:0] rd_mem(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {a + 32'd12, a + 32'd8, a + 32'd4, a};
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!is_ready && n < 20) begin
         step();
         n++;
      end
      check("wait_ready", is_ready, 1);
   endtask

   task automatic check_txn(input string tag, input int i, input logic [31:0] a,
                            input logic we, input logic [127:0] wd);
      if (i < txn_q.size()) begin
         check({tag, "_addr"}, txn_q[i].addr, a);
         check({tag, "_we"}, txn_q[i].we, we);
         if (we) check({tag, "_wdata"}, txn_q[i].wdata, wd);
      end else begin
         check({tag, "_present"}, txn_q.size(), i + 1);
      end
   endtask

   // Drives one request, serves memory traffic (m_ready withheld for 'hold' cycles of
   // each request, response 'lat' cycles after handshake) and checks the completion.
   task automatic run_op(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input bit exp_hit, input logic [31:0] exp_dout,
                         input int hold, input int lat);
      exp_t        e;
      txn_t        t;
      int          cycles = 0;
      int          cnt = 0;
      int          hold_left = hold;
      bit          done = 0;
      bit          pending = 0;
      bit          resp_seen = 0;
      bit          first_seen = 0;
      logic [31:0] cur_addr = '0;
      logic [31:0] first_addr = '0;
      logic        first_we = 1'b0;
      wait_ready();
      e.hit  = exp_hit;
      e.dout = exp_dout;
      sb_q.push_back(e);
      txn_q.delete();
      is_input_valid = 1'b1;
      addr      = a;
      din       = d;
      mem_write = wr;
      mem_read  = !wr;
      step();
      is_input_valid = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      addr      = '0;
      din       = '0;
      while (!done && cycles < 300) begin
         m_ready      = 1'b0;
         m_resp_valid = 1'b0;
         if (is_output_valid) begin
            done = 1;
            check("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check("is_hit", is_hit, e.hit);
               check("dout", dout, e.dout);
            end
            check("resp_before_done", resp_seen, !exp_hit);
            if (exp_hit) check("hit_latency", cycles, 0);
         end else begin
            if (m_req) begin
               if (!first_seen) begin
                  first_seen = 1;
                  first_addr = m_addr;
                  first_we   = m_we;
               end
               if (hold_left > 0) begin
                  hold_left--;
                  check("hold_addr", m_addr, first_addr);
                  check("hold_we", m_we, first_we);
                  check("hold_not_ready", is_ready, 0);
               end else begin
                  m_ready = 1'b1;
                  t.addr  = m_addr;
                  t.we    = m_we;
                  t.wdata = m_wdata;
                  txn_q.push_back(t);
                  if (m_we) mem[m_addr] = m_wdata;
                  cur_addr   = m_addr;
                  pending    = 1;
                  cnt        = lat;
                  first_seen = 0;
                  hold_left  = hold;
               end
            end else if (pending) begin
               cnt--;
               if (cnt <= 0) begin
                  m_resp_valid = 1'b1;
                  m_rdata      = rd_mem(cur_addr);
                  pending      = 0;
                  resp_seen    = 1;
               end
            end
            step();
            cycles++;
         end
      end
      check("completed", done, 1);
      m_ready      = 1'b0;
      m_resp_valid = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      is_input_valid = 1'b0;
      addr           = '0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      din            = '0;
      m_ready        = 1'b0;
      m_resp_valid   = 1'b0;
      m_rdata        = '0;
      mem[32'h100] = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
      mem[32'h200] = {32'h2000000D, 32'h2000000C, 32'h2000000B, 32'h2000000A};

      // Reset values
      repeat (3) step();
      check("rst_is_ready", is_ready, 1);
      check("rst_out_valid", is_output_valid, 0);
      check("rst_m_req", m_req, 0);
      check("rst_dout", dout, 0);
      check("rst_hit_count", hit_count, 0);
      check("rst_miss_count", miss_count, 0);
      rst_n = 1'b1;
      step();

      // Start a miss, reach FILL_WAIT, then reset with m_resp_valid pulsing
      is_input_valid = 1'b1; addr = 32'h300; mem_read = 1'b1;
      step();
      is_input_valid = 1'b0; mem_read = 1'b0; addr = '0;
      step();
      check("abort_m_req", m_req, 1);
      check("abort_m_addr", m_addr, 32'h300);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      check("abort_miss_count", miss_count, 1);
      rst_n = 1'b0; m_resp_valid = 1'b1; m_rdata = {4{32'h5A5A5A5A}};
      step();
      m_resp_valid = 1'b0;
      step();
      m_resp_valid = 1'b1;
      step();
      m_resp_valid = 1'b0;
      rst_n = 1'b1;
      step();
      check("midrst_is_ready", is_ready, 1);
      check("midrst_hit_count", hit_count, 0);
      check("midrst_miss_count", miss_count, 0);
      check("midrst_m_req", m_req, 0);
      m_resp_valid = 1'b1;
      step();
      m_resp_valid = 1'b0;
      step();
      check("idle_resp_ignored_ready", is_ready, 1);
      check("idle_resp_ignored_valid", is_output_valid, 0);
      is_input_valid = 1'b1; addr = 32'h100; mem_read = 1'b1;
      step();
      is_input_valid = 1'b0; mem_read = 1'b0; addr = '0;
      step();
      check("post_rst_m_req", m_req, 1);
      check("post_rst_m_addr", m_addr, 32'h100);
      check("post_rst_m_we", m_we, 0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      // Cold read 0x104, 5-cycle memory
      run_op(0, 32'h104, 0, 0, 32'hBBBB0002, 0, 5);
      check("s2_txn_count", txn_q.size(), 1);
      check_txn("s2_fill", 0, 32'h100, 0, '0);
      check("s2_miss_count", miss_count, 1);
      check("s2_hit_count", hit_count, 0);

      // Hit on the same line
      run_op(0, 32'h10C, 0, 1, 32'hDDDD0004, 0, 1);
      check("s3_txn_count", txn_q.size(), 0);
      step();
      check("s3_hit_count", hit_count, 1);

      // Store hit, read back, store to already-dirty line
      run_op(1, 32'h108, 32'hDEAD, 1, 32'h0, 0, 1);
      run_op(0, 32'h108, 0, 1, 32'hDEAD, 0, 1);
      run_op(1, 32'h100, 32'h1234, 1, 32'h0, 0, 1);
      check("s4_txn_count", txn_q.size(), 0);
      step();
      check("s4_hit_count", hit_count, 4);

      // Conflict miss on dirty line: evict then fill
      run_op(0, 32'h200, 0, 0, 32'h2000000A, 0, 2);
      check("s5_txn_count", txn_q.size(), 2);
      check_txn("s5_evict", 0, 32'h100, 1,
                {32'hDDDD0004, 32'hDEAD, 32'hBBBB0002, 32'h1234});
      if (txn_q.size() > 0) check("s5_wdata_w2", txn_q[0].wdata[95:64], 32'hDEAD);
      check_txn("s5_fill", 1, 32'h200, 0, '0);
      check("s5_miss_count", miss_count, 2);

      // Written-back data returns on the next refill (clean victim: no evict)
      run_op(0, 32'h108, 0, 0, 32'hDEAD, 0, 3);
      check("wb_txn_count", txn_q.size(), 1);
      check_txn("wb_fill", 0, 32'h100, 0, '0);

      // m_ready held low for 10 cycles during FILL_REQ
      run_op(0, 32'h404, 0, 0, 32'h404, 10, 3);
      check("s6_txn_count", txn_q.size(), 1);
      check_txn("s6_fill", 0, 32'h400, 0, '0);

      // Write miss allocates and dirties; next conflict evicts it
      run_op(1, 32'h50C, 32'hCAFE, 0, 32'h0, 0, 2);
      check_txn("wmiss_fill", 0, 32'h500, 0, '0);
      run_op(0, 32'h600, 0, 0, 32'h600, 0, 2);
      check("wmiss_evict_count", txn_q.size(), 2);
      check_txn("wmiss_evict", 0, 32'h500, 1,
                {32'hCAFE, 32'h508, 32'h504, 32'h500});

      // Other index: miss then hit
      run_op(0, 32'h0F4, 0, 0, 32'h0F4, 0, 1);
      run_op(0, 32'h0F4, 0, 1, 32'h0F4, 0, 1);
      step();
      check("final_miss_count", miss_count, 7);
      check("final_hit_count", hit_count, 5);
      check("final_sb_empty", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
